// File: rtl/ltl_c4lw_pkg.sv
// Shared types and constants for the cluster-4 load-word LTL report collector.
// Holds report geometry, record field offsets, the snapshot layout and the
// serializer state encoding.
package ltl_c4lw_pkg;

    localparam int NUM_LTL     = 9;
    localparam int NUM_RPT     = 4;
    localparam int REPORT_W    = NUM_LTL * NUM_RPT;   // 36
    localparam int SYM_W       = 8;
    localparam int LTL_ID_W    = 4;
    localparam int RPT_ID_W    = 2;
    localparam int BIT_IDX_W   = 6;
    localparam int STAMP_MAX_W = 32;

    // Violation record field offsets (LSB positions)
    localparam int REC_SYM_LSB   = 0;
    localparam int REC_PAD_LSB   = 8;
    localparam int REC_RPT_LSB   = 10;
    localparam int REC_LTL_LSB   = 12;
    localparam int REC_STAMP_LSB = 16;

    // Report index within an automaton, by upstream report state
    localparam int RPT_IDX_W_OUT_4  = 0;
    localparam int RPT_IDX_W_OUT_6  = 1;
    localparam int RPT_IDX_W_OUT_9  = 2;
    localparam int RPT_IDX_W_OUT_11 = 3;

    // One captured cycle; stamp is sized for the widest supported STAMP_W
    typedef struct packed {
        logic [REPORT_W-1:0]    mask;
        logic [SYM_W-1:0]       symbol;
        logic [STAMP_MAX_W-1:0] stamp;
    } snap_t;

    localparam int SNAP_W = $bits(snap_t);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } ser_state_t;

    // Per-automaton OR of its four report lines
    function automatic logic [NUM_LTL-1:0] ltl_hits(input logic [REPORT_W-1:0] v);
        logic [NUM_LTL-1:0] h;
        h = '0;
        for (int i = 0; i < NUM_LTL; i++) begin
            h[i] = |v[i*NUM_RPT +: NUM_RPT];
        end
        return h;
    endfunction

endpackage

// File: rtl/ltl_report_collector_c4lw_fifo.sv
// Snapshot FIFO for the LTL report collector. Synchronous FIFO with full/empty
// flags, asynchronous reset, synchronous clear, and push accepted while full
// when a pop happens on the same edge.
module ltl_snap_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_C  = DEPTH[AW:0];
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and occupancy next-state; clear dominates push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are qualified by the occupancy count
    always_ff @(posedge clk) begin
        if (do_push && !clr_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/ltl_report_collector_c4lw.sv
// LTL report collector for cluster-4 load-word stage 0.
// Snapshots every cycle with a fired report, buffers snapshots in a FIFO and
// serializes one 32-bit violation record per fired report on a valid/ready
// stream. Keeps a sticky per-automaton hit summary and overflow diagnostics.
// Build option: define LTL_C4LW_DROP_CNT_EN to implement the saturating
// drop counter; otherwise drop_cnt is tied to zero.
module ltl_report_collector_c4lw
    import ltl_c4lw_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int STAMP_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic [REPORT_W-1:0]   report_vec,
    input  logic [SYM_W-1:0]      symbols_in,
    input  logic                  stage_reset,
    input  logic                  clr_summary,
    output logic                  rpt_valid,
    input  logic                  rpt_ready,
    output logic [STAMP_W+15:0]   rpt_data,
    output logic [NUM_LTL-1:0]    hit_summary,
    output logic                  overflow,
    output logic [7:0]            drop_cnt
);

    localparam logic [STAMP_W-1:0]  STAMP_ONE = 1;
    localparam logic [REPORT_W-1:0] MASK_ONE  = 1;

    logic [STAMP_W-1:0]   stamp_q, stamp_d;
    logic [NUM_LTL-1:0]   hit_q, hit_d;
    logic                 ovf_q, ovf_d;
    ser_state_t           state_q, state_d;
    snap_t                work_q, work_d;
    snap_t                push_snap, head;
    logic [SNAP_W-1:0]    fifo_dout;
    logic                 fifo_full, fifo_empty, fifo_pop;
    logic                 capture, drop_evt;
    logic [BIT_IDX_W-1:0] idx;
    logic [REPORT_W-1:0]  mask_clr;
    logic                 unused_stamp_bits;

    // A cycle is captured only when running, something fired and no soft reset
    assign capture  = run && (|report_vec) && !stage_reset;
    assign drop_evt = capture && fifo_full && !fifo_pop;
    assign head     = fifo_dout;

    assign unused_stamp_bits = ^work_q.stamp;

    // Assemble the snapshot with the pre-increment stamp
    always_comb begin
        push_snap                   = '0;
        push_snap.mask              = report_vec;
        push_snap.symbol            = symbols_in;
        push_snap.stamp[STAMP_W-1:0] = stamp_q;
    end

    ltl_snap_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (SNAP_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (stage_reset),
        .push_i  (capture),
        .pop_i   (fifo_pop),
        .din_i   (push_snap),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Lowest set bit of the work mask selects the record being offered
    always_comb begin
        idx = '0;
        for (int b = REPORT_W - 1; b >= 0; b--) begin
            if (work_q.mask[b]) idx = BIT_IDX_W'(b);
        end
    end

    // Record decode from the work register
    always_comb begin
        rpt_data                               = '0;
        rpt_data[REC_SYM_LSB +: SYM_W]         = work_q.symbol;
        rpt_data[REC_RPT_LSB +: RPT_ID_W]      = idx[1:0];
        rpt_data[REC_LTL_LSB +: LTL_ID_W]      = idx[5:2];
        rpt_data[REC_STAMP_LSB +: STAMP_W]     = work_q.stamp[STAMP_W-1:0];
    end

    // Serializer next-state: load a snapshot in IDLE, retire bits in EMIT
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        fifo_pop  = 1'b0;
        rpt_valid = (state_q == S_EMIT);
        mask_clr  = work_q.mask & ~(MASK_ONE << idx);
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    work_d   = head;
                    fifo_pop = 1'b1;
                    state_d  = S_EMIT;
                end
            end
            S_EMIT: begin
                if (rpt_ready) begin
                    work_d.mask = mask_clr;
                    if (mask_clr == '0) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (stage_reset) begin
            state_d  = S_IDLE;
            work_d   = '0;
            fifo_pop = 1'b0;
        end
    end

    // Serializer state and work register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
        end
    end

    // Stamp, sticky hit summary and overflow next-state
    always_comb begin
        stamp_d = run ? (stamp_q + STAMP_ONE) : stamp_q;
        hit_d   = clr_summary ? '0 : hit_q;
        if (capture) hit_d = hit_d | ltl_hits(report_vec);
        ovf_d   = ovf_q | drop_evt;
        if (stage_reset) begin
            stamp_d = '0;
            hit_d   = '0;
            ovf_d   = 1'b0;
        end
    end

    // Stamp and diagnostic registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stamp_q <= '0;
            hit_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            stamp_q <= stamp_d;
            hit_q   <= hit_d;
            ovf_q   <= ovf_d;
        end
    end

    assign hit_summary = hit_q;
    assign overflow    = ovf_q;

`ifdef LTL_C4LW_DROP_CNT_EN
    logic [7:0] drop_q, drop_d;

    // Saturating count of dropped snapshots
    always_comb begin
        drop_d = drop_q;
        if (stage_reset) begin
            drop_d = '0;
        end else if (drop_evt && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    // Drop counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) drop_q <= '0;
        else       drop_q <= drop_d;
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_ltl_report_collector_c4lw.sv
// Scoreboard testbench for ltl_report_collector_c4lw.
module tb_ltl_report_collector_c4lw;

    logic        clk = 1'b0;
    logic        reset, run, stage_reset, clr_summary, rpt_ready;
    logic [35:0] report_vec;
    logic [7:0]  symbols_in;
    logic        rpt_valid;
    logic [31:0] rpt_data;
    logic [8:0]  hit_summary;
    logic        overflow;
    logic [7:0]  drop_cnt;

    logic [31:0] sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] tb_stamp = '0;

    ltl_report_collector_c4lw #(
        .FIFO_DEPTH (4),
        .STAMP_W    (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .report_vec  (report_vec),
        .symbols_in  (symbols_in),
        .stage_reset (stage_reset),
        .clr_summary (clr_summary),
        .rpt_valid   (rpt_valid),
        .rpt_ready   (rpt_ready),
        .rpt_data    (rpt_data),
        .hit_summary (hit_summary),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // One clock edge; the stamp model follows the run/reset inputs
    task automatic tick();
        @(posedge clk);
        if (reset || stage_reset) tb_stamp = '0;
        else if (run)             tb_stamp = tb_stamp + 16'd1;
        #1;
    endtask

    task automatic expect_snap(input logic [35:0] rv, input logic [7:0] sym);
        for (int b = 0; b < 36; b++) begin
            if (rv[b]) sb.push_back({tb_stamp, 4'(b / 4), 2'(b % 4), 2'b00, sym});
        end
    endtask

    task automatic hit(input logic [35:0] rv, input logic [7:0] sym, input bit keep);
        report_vec = rv;
        symbols_in = sym;
        if (keep) expect_snap(rv, sym);
        tick();
        report_vec = '0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        rpt_ready = 1'b1;
        while (sb.size() != 0 && t < 200) begin
            tick();
            t++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
        tick();
        chk("idle_after_drain", rpt_valid, 1'b0);
    endtask

    // Records are compared just before the edge that accepts them
    always @(negedge clk) begin
        if (!reset && !stage_reset && rpt_valid && rpt_ready) begin
            if (sb.size() == 0) chk("extra_rec", rpt_valid, 1'b0);
            else                chk("rec", rpt_data, sb.pop_front());
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; run = 1'b0; stage_reset = 1'b0; clr_summary = 1'b0;
        rpt_ready = 1'b0; report_vec = '0; symbols_in = '0;
        tick(); tick();
        chk("rst_valid", rpt_valid, 1'b0);
        chk("rst_data", rpt_data, 32'h0);
        chk("rst_hits", hit_summary, 9'h0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_drop", drop_cnt, 8'h0);
        reset = 1'b0;
        tick();

        // Single hit at stamp 0x0010
        run = 1'b1; rpt_ready = 1'b1;
        repeat (16) tick();
        hit(36'h20, 8'hA3, 1'b1);
        chk("sh_valid_capture", rpt_valid, 1'b0);
        chk("sh_hits", hit_summary, 9'b000000010);
        tick();
        chk("sh_valid_next", rpt_valid, 1'b1);
        drain();

        // Multi-bit snapshot: bits 0, 17, 35
        hit(36'h8_0002_0001, 8'h5C, 1'b1);
        drain();
        chk("mb_hits", hit_summary, 9'b100010011);

        // Backpressure for 10 cycles
        rpt_ready = 1'b0;
        hit(36'h204, 8'h11, 1'b1);
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", rpt_valid, 1'b1);
            chk("bp_data", rpt_data, sb[0]);
            tick();
        end
        drain();

        // Overflow: work register busy, then six hit cycles into depth 4
        rpt_ready = 1'b0;
        chk("ovf_pre", overflow, 1'b0);
        hit(36'h2, 8'h01, 1'b1);
        tick();
        for (int i = 0; i < 6; i++) begin
            hit(36'h1 << (4 * i), 8'(8'h40 + i), (i < 4));
        end
        chk("ovf_set", overflow, 1'b1);
`ifdef LTL_C4LW_DROP_CNT_EN
        chk("ovf_drop", drop_cnt, 8'd2);
`else
        chk("ovf_drop", drop_cnt, 8'd0);
`endif
        drain();
        chk("ovf_sticky", overflow, 1'b1);

        // Stage reset mid-drain with a colliding hit
        rpt_ready = 1'b0;
        hit(36'h111, 8'h77, 1'b1);
        tick();
        rpt_ready = 1'b1;
        tick();
        rpt_ready = 1'b0;
        stage_reset = 1'b1;
        report_vec = 36'h1000;
        tick();
        stage_reset = 1'b0;
        report_vec = '0;
        sb.delete();
        chk("sr_valid", rpt_valid, 1'b0);
        chk("sr_hits", hit_summary, 9'h0);
        chk("sr_ovf", overflow, 1'b0);
        chk("sr_drop", drop_cnt, 8'h0);
        chk("sr_data", rpt_data, 32'h0);
        run = 1'b0; rpt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("sr_empty", rpt_valid, 1'b0);
        end
        run = 1'b1;
        hit(36'h8, 8'h3C, 1'b1);
        drain();

        // Clear-summary collision with a hit on automaton 7
        hit(36'h100, 8'h09, 1'b1);
        drain();
        clr_summary = 1'b1;
        hit(36'h1000_0000, 8'hE7, 1'b1);
        clr_summary = 1'b0;
        chk("clr_coll", hit_summary, 9'b010000000);
        drain();
        clr_summary = 1'b1;
        tick();
        clr_summary = 1'b0;
        chk("clr_only", hit_summary, 9'h0);

        chk("sb_left", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ltl_report_collector_c4lw.md
# ltl_report_collector_c4lw

Downstream consumer of the cluster-4 load-word stage-0 automata stage. Takes the 36 report lines (9 LTL automata × 4 report states) plus the forwarded symbol byte and stage reset. Snapshots every cycle in which any report fires, buffers the snapshots, and serializes them into one 32-bit violation record per fired report over a valid/ready stream to the monitor host. Also keeps a sticky per-automaton hit summary and a drop count for overflow diagnosis.

## Interface

**Parameters**
- `FIFO_DEPTH`, default 4: snapshot FIFO entries; must be a power of 2, ≥ 2.
- `STAMP_W`, default 16: width of the cycle stamp.

**Ports**
- `clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-high reset.
- `run` in 1: capture and stamp enable.
- `report_vec` in 36: index = ltl*4 + r.
  - ltl: automaton 0..8.
  - r: report 0..3, mapping to w_out_4, w_out_6, w_out_9, w_out_11.
- `symbols_in` in 8: symbol byte presented in the same cycle as `report_vec`.
- `stage_reset` in 1: synchronous soft reset from the upstream stage's `out_reset`.
- `clr_summary` in 1: single-cycle pulse; clears `hit_summary`.
- `rpt_valid` out 1: record available.
- `rpt_ready` in 1: host accepts the record.
- `rpt_data` out STAMP_W+16: record fields.
  - [STAMP_W+15:16]: stamp.
  - [15:12]: ltl id.
  - [11:10]: report id.
  - [9:8]: 0.
  - [7:0]: symbol.
- `hit_summary` out 9: sticky OR per automaton of captured reports.
- `overflow` out 1: sticky; set when a snapshot is dropped.
- `drop_cnt` out 8: saturating count of dropped snapshots.

## Operation

**Reset**
- `reset` or `stage_reset` clears: the FIFO, the FSM (to IDLE), the stamp, the work mask, `hit_summary`, `overflow` and `drop_cnt`.
- After reset every output is 0.
- `stage_reset` dominates every other event in the same cycle.

**Stamp**
- Increments on each edge with `run`=1.
- Holds when `run`=0.
- Wraps modulo 2^STAMP_W.

**Capture**
- Triggered on an edge where `run`=1 and `report_vec` is non-zero.
- Pushes {`report_vec`, `symbols_in`, stamp} into the FIFO. The stamp used is the pre-increment value.
- On the same edge, `hit_summary[i]` |= OR of `report_vec[4i+3:4i]`. This update happens whether or not the push succeeds.
- FIFO full with no pop on this edge: the snapshot is dropped, `overflow` is set to 1, and `drop_cnt` increments and saturates at 255.
- Full with a simultaneous pop: the push succeeds.

**Serializer FSM**
- IDLE
  - FIFO non-empty: load the head into the work register (mask, symbol, stamp), pop it, go to EMIT.
- EMIT
  - `rpt_valid`=1.
  - `rpt_data` is built from the lowest set bit b of the work mask: ltl = b/4, rpt = b%4.
  - On `rpt_valid` && `rpt_ready`: clear bit b.
  - If no set bits remain after that clear, go to IDLE.
- Records from one snapshot are emitted in ascending bit order.
- There is always one IDLE bubble between snapshots.

**Stream rules**
- Once `rpt_valid` is high, `rpt_data` is stable and `rpt_valid` stays high until it is accepted.
- `run`=0 does not stall draining.

**`clr_summary`**
- Zeroes `hit_summary`.
- If a capture happens on the same edge, that capture's bits are still set, because the set wins.

## Timing

- Report in cycle k (captured at edge k):
  - load at edge k+1;
  - `rpt_valid` high from cycle k+1 after the edge;
  - first record accepted no earlier than edge k+2.
- With `rpt_ready` held at 1, one record per cycle within a snapshot.
- `hit_summary`, `overflow` and `drop_cnt` are visible one cycle after the capture edge.
- All outputs are registered except `rpt_data`, which is decoded from the work register by a priority encoder (combinational).

## Configuration

- Macro: `LTL_C4LW_DROP_CNT_EN`.
- Defined: the `drop_cnt` counter is implemented as specified.
- Undefined: the counter logic is removed and `drop_cnt` is tied to 0. `overflow` is still implemented.

## Structure

- Package `ltl_c4lw_pkg` holds:
  - `NUM_LTL`=9, `NUM_RPT`=4, `REPORT_W`=36;
  - the record field offsets;
  - the snapshot struct typedef (mask, symbol, stamp);
  - the report-index constants for 4/6/9/11.
- Sub-module `ltl_snap_fifo`: synchronous FIFO with full/empty flags, async `reset`, sync clear input, and push+pop allowed when full.

## Test plan

- **Single hit:** `report_vec` bit 5 with symbol 0xA3 at stamp 0x0010, `rpt_ready`=1.
  - One record: ltl 1, rpt 1, symbol 0xA3, stamp 0x0010.
  - `rpt_valid` rises one cycle after capture.
  - `hit_summary` = 9'b000000010.
- **Multi-bit snapshot:** bits 0, 35 and 17 set in one cycle.
  - Three records in order (0,0), (4,1), (8,3), all carrying the same stamp and symbol.
- **Backpressure:** hold `rpt_ready`=0 for 10 cycles with a pending record.
  - `rpt_valid` and `rpt_data` stay constant.
  - After release, every record is delivered exactly once.
- **Overflow:** `rpt_ready`=0 with 6 consecutive hit cycles (depth 4).
  - 4 snapshots are retained.
  - `overflow`=1 and `drop_cnt`=2 (0 when the macro is undefined).
- **Stage reset mid-drain:** pulse `stage_reset` while in EMIT with 2 records left and a hit arriving in the same cycle.
  - Next cycle: `rpt_valid`=0, FIFO empty, the hit is not captured, stamp = 0, `hit_summary` = 0.
- **Clear-summary collision:** `clr_summary` in the same cycle as a hit on ltl 7.
  - `hit_summary` = 9'b010000000.
